// File: rtl/execute_stage_m_if.sv
// Execute-stage bus: ID/EX control and operands in, hazard and branch results and the
// EX/MEM register contents out.
//   master : drives the ID/EX side, observes the results (pipeline or bench)
//   slave  : the execute stage itself
interface execute_stage_m_if #(
    parameter int unsigned XLEN = 32
);
    // ID/EX side
    logic            RegWriteE;
    logic            MemWriteE;
    logic            MemReadE;
    logic            ResultSrcE;
    logic            ALUSrcE;
    logic [2:0]      BranchE;
    logic [3:0]      ALUControlE;
    logic            MulDivE;
    logic [2:0]      MulDivOpE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ResultW;
    logic [4:0]      RD_E;
    logic [1:0]      ForwardA_E;
    logic [1:0]      ForwardB_E;
    logic            StallE;
    logic            PipelineFlush;
    // Results and EX/MEM register
    logic            BusyE;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            MemReadM;
    logic            ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] ALU_ResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;

    modport master (
        output RegWriteE, MemWriteE, MemReadE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
               MulDivE, MulDivOpE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW, RD_E,
               ForwardA_E, ForwardB_E, StallE, PipelineFlush,
        input  BusyE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, MemReadM, ResultSrcM, RD_M,
               ALU_ResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, MemWriteE, MemReadE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
               MulDivE, MulDivOpE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW, RD_E,
               ForwardA_E, ForwardB_E, StallE, PipelineFlush,
        output BusyE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, MemReadM, ResultSrcM, RD_M,
               ALU_ResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_stage_m.sv
// RV32/RV64 execute stage: operand forwarding, ALU, branch resolution, an iterative
// multiply/divide unit (one bit per cycle) and the EX/MEM pipeline register.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   ex_if : execute bus (slave); ID/EX controls/operands in, BusyE/PCSrcE/PCTargetE and
//           the EX/MEM register out
module execute_stage_m #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input logic              clk,
    input logic              rst,
    execute_stage_m_if.slave ex_if
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} md_state_e;

    md_state_e          r_state, w_state_next;
    logic [SHAMT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_hi, r_lo, r_opb;
    logic [2:0]         r_op;
    logic               r_neg, r_neg_rem, r_div_zero;

    logic               r_reg_write_m, r_mem_write_m, r_mem_read_m, r_result_src_m;
    logic [4:0]         r_rd_m;
    logic [XLEN-1:0]    r_alu_result_m, r_write_data_m, r_pc_plus4_m;

    logic [XLEN-1:0]    w_src_a, w_src_b_int, w_src_b, w_alu_result;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_eq, w_lt, w_ltu, w_taken, w_busy, w_start;

    // Forwarding muxes; code 3 falls back to the register file.
    always_comb begin
        unique case (ex_if.ForwardA_E)
            2'd1:    w_src_a = ex_if.ResultW;
            2'd2:    w_src_a = r_alu_result_m;
            default: w_src_a = ex_if.RD1_E;
        endcase
        unique case (ex_if.ForwardB_E)
            2'd1:    w_src_b_int = ex_if.ResultW;
            2'd2:    w_src_b_int = r_alu_result_m;
            default: w_src_b_int = ex_if.RD2_E;
        endcase
    end

    assign w_src_b = ex_if.ALUSrcE ? ex_if.ImmExtE : w_src_b_int;
    assign w_shamt = w_src_b[SHAMT_W-1:0];

    always_comb begin
        w_alu_result = '0;
        case (ex_if.ALUControlE)
            4'd0: w_alu_result = w_src_a + w_src_b;
            4'd1: w_alu_result = w_src_a - w_src_b;
            4'd2: w_alu_result = w_src_a & w_src_b;
            4'd3: w_alu_result = w_src_a | w_src_b;
            4'd4: w_alu_result = w_src_a ^ w_src_b;
            4'd5: w_alu_result = w_src_a << w_shamt;
            4'd6: w_alu_result = w_src_a >> w_shamt;
            4'd7: w_alu_result = $signed(w_src_a) >>> w_shamt;
            4'd8: w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
            4'd9: w_alu_result = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
            default: w_alu_result = '0;
        endcase
    end

    // Branch compare always uses the register operand, never the immediate.
    assign w_eq  = (w_src_a == w_src_b_int);
    assign w_lt  = ($signed(w_src_a) < $signed(w_src_b_int));
    assign w_ltu = (w_src_a < w_src_b_int);

    always_comb begin
        w_taken = 1'b0;
        case (ex_if.BranchE)
            3'd1: w_taken = w_eq;
            3'd2: w_taken = ~w_eq;
            3'd3: w_taken = w_lt;
            3'd4: w_taken = ~w_lt;
            3'd5: w_taken = w_ltu;
            3'd6: w_taken = ~w_ltu;
            3'd7: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign ex_if.PCSrcE    = w_taken & ~ex_if.MulDivE & ~ex_if.PipelineFlush;
    assign ex_if.PCTargetE = ex_if.PCE + ex_if.ImmExtE;

    // ---------------- multiply/divide unit ----------------
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic [XLEN:0]   w_sum, w_rem_sh, w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_quo, w_rem, w_md_result;

    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        unique case (ex_if.MulDivOpE)
            3'd1, 3'd4, 3'd6: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'd2:    w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_a_neg = w_a_signed & w_src_a[XLEN-1];
    assign w_b_neg = w_b_signed & w_src_b_int[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_src_a : w_src_a;
    assign w_b_mag = w_b_neg ? -w_src_b_int : w_src_b_int;

    assign w_start = (r_state == StIdle) & ex_if.MulDivE & ~ex_if.PipelineFlush;
    assign w_busy  = w_start | (r_state == StRun);
    assign ex_if.BusyE = w_busy;

    // Multiply: {r_hi, r_lo} is the shifting product, r_lo starts as the multiplier.
    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opb};

    assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    // Signed overflow falls out naturally: |min|/1 = min with positive sign.
    assign w_quo  = r_div_zero ? '1 : (r_neg ? -r_lo : r_lo);
    assign w_rem  = r_neg_rem ? -r_hi : r_hi;

    always_comb begin
        unique case (r_op)
            3'd0:             w_md_result = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_md_result = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_md_result = w_quo;
            default:          w_md_result = w_rem;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (ex_if.MulDivE) w_state_next = StRun;
            StRun:   if (r_cnt == '0) w_state_next = StDone;
            StDone:  if (!ex_if.StallE) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        if (ex_if.PipelineFlush) w_state_next = StIdle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_op       <= '0;
            r_neg      <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_cnt      <= SHAMT_W'(XLEN - 1);
                r_hi       <= '0;
                r_lo       <= w_a_mag;
                r_opb      <= w_b_mag;
                r_op       <= ex_if.MulDivOpE;
                r_neg      <= w_a_neg ^ w_b_neg;
                r_neg_rem  <= w_a_neg;
                r_div_zero <= (w_src_b_int == '0);
            end else if (r_state == StRun) begin
                if (r_cnt != '0) r_cnt <= r_cnt - SHAMT_W'(1);
                if (r_op[2]) begin
                    if (!w_diff[XLEN]) begin
                        r_hi <= w_diff[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b1};
                    end else begin
                        r_hi <= w_rem_sh[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
                end
            end
        end
    end

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || ex_if.PipelineFlush || (!ex_if.StallE && w_busy)) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_mem_read_m   <= 1'b0;
            r_result_src_m <= 1'b0;
            r_rd_m         <= '0;
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_pc_plus4_m   <= '0;
        end else if (!ex_if.StallE) begin
            r_reg_write_m  <= ex_if.RegWriteE;
            r_mem_write_m  <= ex_if.MemWriteE;
            r_mem_read_m   <= ex_if.MemReadE;
            r_result_src_m <= ex_if.ResultSrcE;
            r_rd_m         <= ex_if.RD_E;
            r_alu_result_m <= (r_state == StDone) ? w_md_result : w_alu_result;
            r_write_data_m <= w_src_b_int;
            r_pc_plus4_m   <= ex_if.PCPlus4E;
        end
    end

    assign ex_if.RegWriteM   = r_reg_write_m;
    assign ex_if.MemWriteM   = r_mem_write_m;
    assign ex_if.MemReadM    = r_mem_read_m;
    assign ex_if.ResultSrcM  = r_result_src_m;
    assign ex_if.RD_M        = r_rd_m;
    assign ex_if.ALU_ResultM = r_alu_result_m;
    assign ex_if.WriteDataM  = r_write_data_m;
    assign ex_if.PCPlus4M    = r_pc_plus4_m;
endmodule

// File: tb/tb_execute_stage_m.sv
module tb_execute_stage_m;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_stage_m_if #(.XLEN(XLEN)) ex_if ();
    execute_stage_m #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rst  (rst),
        .ex_if(ex_if)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return 32'($signed(a) >>> b[4:0]);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        ex_if.RegWriteE     = 1'b0;
        ex_if.MemWriteE     = 1'b0;
        ex_if.MemReadE      = 1'b0;
        ex_if.ResultSrcE    = 1'b0;
        ex_if.ALUSrcE       = 1'b0;
        ex_if.BranchE       = 3'd0;
        ex_if.ALUControlE   = 4'd0;
        ex_if.MulDivE       = 1'b0;
        ex_if.MulDivOpE     = 3'd0;
        ex_if.RD1_E         = '0;
        ex_if.RD2_E         = '0;
        ex_if.ImmExtE       = '0;
        ex_if.PCE           = '0;
        ex_if.PCPlus4E      = '0;
        ex_if.RD_E          = '0;
        ex_if.ForwardA_E    = 2'd0;
        ex_if.ForwardB_E    = 2'd0;
        ex_if.StallE        = 1'b0;
        ex_if.PipelineFlush = 1'b0;
    endtask

    // One ALU instruction issued at a negedge; returns at the next negedge with it still
    // on the ID/EX inputs so a following instruction can issue back-to-back.
    task automatic drive_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] rd,
                             input logic [31:0] exp);
        idle();
        ex_if.RegWriteE   = 1'b1;
        ex_if.ALUControlE = ctl;
        ex_if.RD1_E       = a;
        ex_if.RD2_E       = b;
        ex_if.ForwardA_E  = fa;
        ex_if.ForwardB_E  = fb;
        ex_if.RD_E        = rd;
        ex_if.PCPlus4E    = 32'h44;
        sb_q.push_back('{exp, rd});
        @(negedge clk);
    endtask

    task automatic set_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        idle();
        ex_if.RegWriteE = 1'b1;
        ex_if.MulDivE   = 1'b1;
        ex_if.MulDivOpE = op;
        ex_if.RD1_E     = a;
        ex_if.RD2_E     = b;
        ex_if.RD_E      = 5'd9;
    endtask

    // Waits until the unit reaches DONE; returns the number of busy cycles and bubbles seen.
    task automatic wait_done(output int n, output int bub);
        n   = 0;
        bub = 0;
        do begin
            @(negedge clk);
            n++;
            if (ex_if.RegWriteM) bub++;
        end while (ex_if.BusyE && n < 100);
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n, bub;
        set_md(op, a, b);
        sb_q.push_back('{exp, 5'd9});
        wait_done(n, bub);
        check_eq({tag, "_lat"}, 64'(n), 64'd33);
        check_eq({tag, "_bub"}, 64'(bub), 64'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_res"}, ex_if.ALU_ResultM, exp);
        idle();
        @(negedge clk);
    endtask

    task automatic br(input string tag, input logic [2:0] bt, input logic [31:0] a,
                      input logic [31:0] b, input logic exp);
        ex_if.BranchE = bt;
        ex_if.RD1_E   = a;
        ex_if.RD2_E   = b;
        #1;
        check_eq(tag, ex_if.PCSrcE, exp);
    endtask

    // Scoreboard consumer: every newly loaded writing instruction in M pops one entry.
    always @(posedge clk) begin
        logic ld;
        exp_t e;
        ld = rst && !ex_if.StallE && !ex_if.PipelineFlush;
        #1;
        if (ld && ex_if.RegWriteM) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", ex_if.ALU_ResultM, 64'hDEAD);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_res", ex_if.ALU_ResultM, e.res);
                check_eq("sb_rd", ex_if.RD_M, e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int n, bub;
        logic [31:0] a, b;
        idle();
        ex_if.ResultW = '0;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_result", ex_if.ALU_ResultM, 0);
        check_eq("rst_regwr", ex_if.RegWriteM, 0);
        check_eq("rst_wdata", ex_if.WriteDataM, 0);
        check_eq("rst_busy", ex_if.BusyE, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Forwarding: 7 in M, then 7 + 0xFFFFFFFE via ForwardA=2.
        drive_alu(4'd0, 32'd3, 32'd4, 2'd0, 2'd0, 5'd1, 32'd7);
        drive_alu(4'd0, 32'd5, 32'hFFFF_FFFE, 2'd2, 2'd0, 5'd2, 32'd5);
        ex_if.ResultW = 32'h100;
        drive_alu(4'd1, 32'h300, 32'h5, 2'd0, 2'd1, 5'd3, 32'h200);
        drive_alu(4'd0, 32'd1, 32'd2, 2'd3, 2'd0, 5'd4, 32'd3);

        for (int c = 0; c < 12; c++) begin
            a = $urandom;
            b = $urandom;
            if (c == 7) a[31] = 1'b1;
            drive_alu(4'(c), a, b, 2'd0, 2'd0, 5'(c + 5), alu_ref(4'(c), a, b));
        end

        // Immediate operand; store data still comes from the register operand.
        idle();
        ex_if.RegWriteE = 1'b1;
        ex_if.MemWriteE = 1'b1;
        ex_if.ALUSrcE   = 1'b1;
        ex_if.RD1_E     = 32'h10;
        ex_if.RD2_E     = 32'hABCD;
        ex_if.ImmExtE   = 32'h20;
        ex_if.RD_E      = 5'd7;
        sb_q.push_back('{32'h30, 5'd7});
        @(negedge clk);
        check_eq("imm_wdata", ex_if.WriteDataM, 32'hABCD);
        check_eq("imm_memwr", ex_if.MemWriteM, 1);

        // Branches (combinational, no writes).
        idle();
        br("bltu", 3'd5, 32'd1, 32'hFFFF_FFFF, 1'b1);
        br("blt", 3'd3, 32'd1, 32'hFFFF_FFFF, 1'b0);
        br("beq_t", 3'd1, 32'd5, 32'd5, 1'b1);
        br("beq_n", 3'd1, 32'd5, 32'd6, 1'b0);
        br("bne", 3'd2, 32'd5, 32'd6, 1'b1);
        br("bge", 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
        br("bgeu", 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1);
        br("jal", 3'd7, 32'd0, 32'd9, 1'b1);
        br("none", 3'd0, 32'd5, 32'd5, 1'b0);
        @(negedge clk);
        ex_if.ALUSrcE = 1'b1;
        ex_if.ImmExtE = 32'd5;
        br("beq_imm", 3'd1, 32'd5, 32'd6, 1'b0);
        ex_if.ALUSrcE = 1'b0;
        ex_if.PCE     = 32'h1000;
        ex_if.ImmExtE = 32'hFFFF_FFF0;
        #1;
        check_eq("pctarget", ex_if.PCTargetE, 32'h0FF0);
        ex_if.MulDivE = 1'b1;
        br("jal_md", 3'd7, 32'd0, 32'd0, 1'b0);
        ex_if.MulDivE       = 1'b0;
        ex_if.PipelineFlush = 1'b1;
        br("jal_flush", 3'd7, 32'd0, 32'd0, 1'b0);
        idle();
        @(negedge clk);

        run_md("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_md("mul", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
        run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("div0", 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_md("rem0", 3'd6, 32'd7, 32'd0, 32'd7);
        run_md("divov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("remov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_md("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        run_md("divneg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_md("remneg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_md("remu", 3'd7, 32'hFFFF_FFFF, 32'd10, 32'd5);

        // Flush during RUN cycle 10 of a DIV: nothing may reach M.
        set_md(3'd4, 32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        check_eq("fl_busy_run", ex_if.BusyE, 1);
        ex_if.PipelineFlush = 1'b1;
        @(negedge clk);
        idle();
        #1;
        check_eq("fl_busy", ex_if.BusyE, 0);
        check_eq("fl_regwr", ex_if.RegWriteM, 0);
        @(negedge clk);
        drive_alu(4'd0, 32'h11, 32'h22, 2'd0, 2'd0, 5'd12, 32'h33);
        idle();
        @(negedge clk);
        check_eq("fl_add", ex_if.ALU_ResultM, 0);

        // Downstream stall for three cycles while in DONE.
        set_md(3'd5, 32'd100, 32'd7);
        sb_q.push_back('{32'd14, 5'd9});
        wait_done(n, bub);
        check_eq("stl_lat", 64'(n), 64'd33);
        ex_if.StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stl_busy", ex_if.BusyE, 0);
            check_eq("stl_hold", ex_if.RegWriteM, 0);
        end
        ex_if.StallE = 1'b0;
        @(posedge clk);
        #1;
        check_eq("stl_res", ex_if.ALU_ResultM, 32'd14);
        idle();
        @(negedge clk);

        // Asynchronous reset mid-MUL while EX/MEM holds an older result.
        drive_alu(4'd0, 32'h1000, 32'h234, 2'd0, 2'd0, 5'd3, 32'h1234);
        set_md(3'd0, 32'd6, 32'd7);
        ex_if.StallE = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("ar_pre_res", ex_if.ALU_ResultM, 32'h1234);
        check_eq("ar_pre_busy", ex_if.BusyE, 1);
        idle();
        rst = 1'b0;
        #1;
        check_eq("ar_res", ex_if.ALU_ResultM, 0);
        check_eq("ar_regwr", ex_if.RegWriteM, 0);
        check_eq("ar_rd", ex_if.RD_M, 0);
        check_eq("ar_pc4", ex_if.PCPlus4M, 0);
        check_eq("ar_busy", ex_if.BusyE, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        repeat (3) @(negedge clk);
        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
